mdu_sched: RTL and testbench

// - Multiply/divide unit with its own scheduler for the 5-stage pipelined mips core; sits in the E stage beside the ALU.
// - Owns the HI/LO registers and runs each mult/div for a fixed number of cycles.
// - Drives the stall request that the hazard unit ORs into its D-stage freeze.

---
 rtl/mdu_sched.sv | 165 ++++++++++++++++
 tb/tb_mdu_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched -- multiply/divide unit with its own issue scheduler.
//
// Sits in the E stage beside the ALU of the 5-stage pipelined core. It owns the
// HI/LO registers. MULT/MULTU occupy the unit for MULT_CYCLES cycles and
// DIV/DIVU for DIV_CYCLES cycles. The stall output is ORed by the hazard unit
// into its D-stage freeze.
//
// The full 64-bit result is computed at issue and held in a shadow register.
// It is copied to HI/LO on the edge that ends the last busy cycle, so software
// can only observe the fixed latency.
//
// Ports
//   clk     in   1  core clock
//   reset   in   1  synchronous, active-high
//   start   in   1  E-stage instruction is an MD write op this cycle
//   op      in   3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a       in  32  rs operand (forwarded)
//   b       in  32  rt operand (forwarded)
//   md_use  in   1  D-stage instruction is MD-class
//   busy    out  1  an operation is in flight
//   stall   out  1  freeze D, bubble into E
//   hi      out 32  HI register
//   lo      out 32  LO register
//
// Configuration macro: MDU_DIV0_GUARD_EN
//   Defined:   DIV/DIVU with b==0 is dropped at issue. There is no busy period
//              and no stall, and HI/LO are left untouched.
//   Undefined: the divide runs its full latency and commits hi=a, lo=all-ones.

`timescale 1ns/1ps

module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        div0_drop;
    logic        md_req;

    // Returns {hi, lo} for ops 0..3.
    // Division by zero yields {dividend, all-ones}.
    // The single signed overflow case (most-negative / -1) saturates the
    // quotient to 0x80000000 with a zero remainder, rather than trapping.
    function automatic logic [63:0] md_result(input logic [2:0]  f_op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic signed [31:0] sx, sy, sq, sr;
        sx    = x;
        sy    = y;
        sprod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        uprod = {32'd0, x} * {32'd0, y};
        sq    = '0;
        sr    = '0;
        case (f_op)
            3'd0: return sprod;
            3'd1: return uprod;
            3'd2: begin
                if (y == 32'd0) begin
                    return {x, 32'hFFFF_FFFF};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    return {32'd0, 32'h8000_0000};
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    return {sr, sq};
                end
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                else            return {x % y, x / y};
            end
            default: return 64'd0;
        endcase
    endfunction

`ifdef MDU_DIV0_GUARD_EN
    assign div0_drop = (op[2:1] == 2'b01) && (b == 32'd0);
`else
    assign div0_drop = 1'b0;
`endif

    // A mult/div that would actually be issued.
    // The stall term uses this too, so a dropped divide never freezes D.
    assign md_req = start && (op <= 3'd3) && !div0_drop;

    assign busy  = (state_q == RUN);
    assign stall = md_use && (busy || md_req);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (md_req) begin
                    {res_hi_d, res_lo_d} = md_result(op, a, b);
                    cnt_d   = op[1] ? DIV_LAST : MULT_LAST;
                    state_d = RUN;
                end else if (start && op == 3'd4) begin
                    hi_d = a;
                end else if (start && op == 3'd5) begin
                    lo_d = a;
                end
            end
            RUN: begin
                // start is ignored here; the hazard unit never issues while busy.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // The shadow is only read after it has been loaded at issue, so it
        // needs no reset.
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched -- self-checking bench for mdu_sched.
//
// Directed scenarios and randomized op sequences are checked against a
// behavioural model. The model is built from plain 64-bit arithmetic plus the
// latency and commit rules of the unit.

`timescale 1ns/1ps

module tb_mdu_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset, start, md_use;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi, exp_lo;

    mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use(md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #1 clk = ~clk;

    // The bench must never issue while the unit is busy.
    always @(negedge clk) begin
        if (!reset && busy === 1'b1 && start === 1'b1) begin
            errors++;
            $display("FAIL start_while_busy: start=1 busy=1, required no issue while busy");
        end
    end

    // Reference result {hi, lo} for ops 0..3, built from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0]  o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: return sx * sy;
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx - q * sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Issue one op, follow it to completion, and check stall, busy length and HI/LO.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic md, input string name);
        logic runs;
        int   n, want_n;
        logic [63:0] r;
        runs = (o <= 3'd3);
`ifdef MDU_DIV0_GUARD_EN
        if ((o == 3'd2 || o == 3'd3) && y == 32'd0) runs = 1'b0;
`endif
        want_n = (o >= 3'd2) ? DIV_N : MULT_N;
        r = ref_result(o, x, y);

        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; md_use = md;
        #0.2;
        checks++;
        if (stall !== (md & runs)) begin
            errors++;
            $display("FAIL %s_issue_stall: got %b want %b", name, stall, md & runs);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;

        if (runs) begin
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                checks++;
                if (stall !== md) begin
                    errors++;
                    $display("FAIL %s_busy_stall: cycle %0d got %b want %b", name, n, stall, md);
                end
                @(negedge clk);
            end
            checks++;
            if (n != want_n) begin
                errors++;
                $display("FAIL %s_busy_len: got %0d cycles want %0d", name, n, want_n);
            end
            {exp_hi, exp_lo} = r;
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: got %b want 0", name, busy);
            end
            if (o == 3'd4) exp_hi = x;
            if (o == 3'd5) exp_lo = x;
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall_after: got %b want 0", name, stall);
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_hilo: got hi=%h lo=%h want hi=%h lo=%h",
                     name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; md_use = 1'b1;
        #100;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b stall=%b hi=%h lo=%h want 0 0 0 0",
                     busy, stall, hi, lo);
        end
        reset = 1'b0;
        md_use = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_mult();
        run_op(3'd0, -32'sd3, 32'sd7, 1'b0, "mult_neg");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_const: got hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
        end
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin
            errors++;
            $display("FAIL multu_const: got hi=%h lo=%h want fffffffe 00000001", hi, lo);
        end
    endtask

    task automatic test_div_stall();
        run_op(3'd2, -32'sd7, 32'sd2, 1'b1, "div_stall");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_const: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        checks++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_ovf_const: got hi=%h lo=%h want 00000000 80000000", hi, lo);
        end
        md_use = 1'b0;
    endtask

    task automatic test_move_then_mult();
        run_op(3'd5, 32'h1234, 32'd0, 1'b0, "mtlo");
        checks++;
        if (lo !== 32'h1234) begin
            errors++;
            $display("FAIL mtlo_const: got lo=%h want 00001234", lo);
        end
        run_op(3'd4, 32'hCAFE_0001, 32'd0, 1'b1, "mthi");
        run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b1, "reserved");
        run_op(3'd0, 32'd2, 32'd3, 1'b0, "mult_small");
        checks++;
        if (hi !== 32'd0 || lo !== 32'd6) begin
            errors++;
            $display("FAIL mult_small_const: got hi=%h lo=%h want 0 6", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        // Now in busy cycle 1; advance to busy cycle 4 before asserting reset.
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_late: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        exp_hi = '0;
        exp_lo = '0;
    endtask

    task automatic test_div0();
        run_op(3'd4, 32'h0BAD_F00D, 32'd0, 1'b0, "pre_mthi");
        run_op(3'd3, 32'd5, 32'd0, 1'b1, "divu_zero");
`ifdef MDU_DIV0_GUARD_EN
        checks++;
        if (hi !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL divu_zero_const: got hi=%h want 0badf00d", hi);
        end
`else
        checks++;
        if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divu_zero_const: got hi=%h lo=%h want 00000005 ffffffff", hi, lo);
        end
`endif
        run_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1'b1, "div_zero");
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(o, x, y, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_stall();
        test_move_then_mult();
        test_reset_mid();
        test_div0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
